// File: rtl/edac_pkg.sv
// Shared constants and helpers for the 4-bit EDAC codec pair.
// The crc4 function is used by both the encoder and the decoder, so a word
// encoded with a given polynomial always re-checks cleanly on the decode side.
package edac_pkg;

  // Hamming-protected field width (positions 1..12) and full codeword width
  localparam int HAM_W  = 12;
  localparam int CODE_W = 16;

  // Extracted byte: {payload nibble, crc nibble}
  localparam int DATA_W = 8;

  // Syndromes 1..12 name a real bit position; 13..15 cannot come from a single error
  localparam logic [3:0] SYN_MAX_CORR = 4'd12;

  // Word held in the Hamming stage while it waits for the CRC stage
  typedef struct packed {
    logic [DATA_W-1:0] data;     // {payload, rx_crc} after correction
    logic [3:0]        syn;      // raw syndrome
    logic              corr;     // a bit was flipped
    logic              bad_syn;  // syndrome outside the correctable range
    logic              hi_nz;    // reserved codeword bits were non-zero
    logic [3:0]        poly;     // polynomial captured with this word
  } s1_word_t;

  // CRC4 exactly as the encoder computes it: shift the polynomial right
  // while walking the payload bits from MSB down.
  function automatic logic [3:0] crc4(input logic [3:0] payload, input logic [3:0] poly);
    logic [7:0] t;
    logic [7:0] p;
    t = {payload, 4'b0000};
    p = {poly, 4'b0000};
    for (int k = 7; k >= 4; k--) begin
      if (t[k]) t = t ^ p;
      p = p >> 1;
    end
    return t[3:0];
  endfunction

endpackage

// File: rtl/edac_ham12_correct.sv
// Combinational Hamming(12) syndrome, single-bit correction and extraction
// of the eight data positions {c11,c10,c9,c8,c6,c5,c4,c2}.
module edac_ham12_correct
  import edac_pkg::*;
(
  input  logic [HAM_W-1:0]  code,
  output logic [3:0]        syndrome,
  output logic [DATA_W-1:0] data,
  output logic              corr,
  output logic              bad_syn
);

  logic [HAM_W-1:0] flip_mask;

  // Syndrome: each bit is the parity over the positions whose index has that bit set
  always_comb begin
    syndrome[0] = ^{code[0], code[2], code[4], code[6], code[8], code[10]};
    syndrome[1] = ^{code[1], code[2], code[5], code[6], code[9], code[10]};
    syndrome[2] = ^{code[3], code[4], code[5], code[6], code[11]};
    syndrome[3] = ^{code[7], code[8], code[9], code[10], code[11]};
  end

  // One-hot flip mask; all-zero for syndrome 0 and for the illegal range 13..15
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < HAM_W; i++) begin
      flip_mask[i] = (syndrome == 4'(i + 1));
    end
  end

  // Apply the correction only to the data positions and raise the status flags
  always_comb begin
    data    = {code[11], code[10], code[9], code[8], code[6], code[5], code[4], code[2]}
            ^ {flip_mask[11], flip_mask[10], flip_mask[9], flip_mask[8],
               flip_mask[6], flip_mask[5], flip_mask[4], flip_mask[2]};
    corr    = |flip_mask;
    bad_syn = (syndrome > SYN_MAX_CORR);
  end

endmodule

// File: rtl/edac_decode_4bit_pipe.sv
// Two-stage EDAC decoder: stage 1 corrects the Hamming word, stage 2 re-checks
// the CRC4 and presents payload plus status. Saturating event counters count
// delivered words.
//
// Handshake: a word moves on valid && ready at a rising edge. Each stage loads
// when it is empty or when its content moves on in the same cycle, so the pipe
// sustains one word per cycle and holds its output stable while out_valid is
// high and out_ready is low. in_ready depends only on register state and
// out_ready, never on in_valid.
module edac_decode_4bit_pipe
  import edac_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [7:0]        crc_poly,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [3:0]        out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              s1_valid;
  s1_word_t          s1_q;
  s1_word_t          s1_d;
  logic              s1_load;
  logic              s2_load;
  logic              deliver;
  logic [3:0]        ham_syn;
  logic [DATA_W-1:0] ham_data;
  logic              ham_corr;
  logic              ham_bad;
  logic [3:0]        crc_calc;
  logic              crc_bad;
  logic              unused_poly_hi;

  // Only the low nibble of the polynomial is meaningful for a 4-bit CRC
  assign unused_poly_hi = ^crc_poly[7:4];

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign deliver  = out_valid && out_ready;

  edac_ham12_correct u_ham (
    .code     (in_code[HAM_W-1:0]),
    .syndrome (ham_syn),
    .data     (ham_data),
    .corr     (ham_corr),
    .bad_syn  (ham_bad)
  );

  // Assemble the stage-1 word from the corrector and the raw inputs
  always_comb begin
    s1_d         = '0;
    s1_d.data    = ham_data;
    s1_d.syn     = ham_syn;
    s1_d.corr    = ham_corr;
    s1_d.bad_syn = ham_bad;
    s1_d.hi_nz   = |in_code[CODE_W-1:HAM_W];
    s1_d.poly    = crc_poly[3:0];
  end

  // CRC re-check on the word held in stage 1, using the polynomial captured with it
  always_comb begin
    crc_calc = crc4(s1_q.data[7:4], s1_q.poly);
    crc_bad  = (crc_calc != s1_q.data[3:0]);
  end

  // Stage 1: capture corrected word and the polynomial that belongs to it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: CRC verdict and output registers, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_corr     <= 1'b0;
      out_uncorr   <= 1'b0;
      out_syndrome <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= s1_q.data[7:4];
        out_corr     <= s1_q.corr;
        out_uncorr   <= s1_q.bad_syn || s1_q.hi_nz || crc_bad;
        out_syndrome <= s1_q.syn;
      end
    end
  end

  // Saturating event counters; a clear wins over an increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (deliver) begin
      if (out_uncorr) begin
        if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end else if (out_corr) begin
        if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_edac_decode_4bit_pipe.sv
// Bench for edac_decode_4bit_pipe: directed vectors, backpressure, random
// traffic against a positional Hamming/CRC reference, counter saturation,
// clear and mid-stream reset.
module tb_edac_decode_4bit_pipe;

  localparam int CNT_W = 8;
  localparam int DPOS [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, out_valid, out_ready;
  logic [15:0]      in_code;
  logic [7:0]       crc_poly;
  logic [3:0]       out_data, out_syndrome;
  logic             out_corr, out_uncorr, cnt_clr;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

  edac_decode_4bit_pipe #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .crc_poly     (crc_poly),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_corr     (out_corr),
    .out_uncorr   (out_uncorr),
    .out_syndrome (out_syndrome),
    .cnt_clr      (cnt_clr),
    .corr_cnt     (corr_cnt),
    .uncorr_cnt   (uncorr_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int bp_mode  = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

  // expected word: {data[3:0], corr, uncorr, syndrome[3:0]}
  logic [9:0]       exp_q[$];
  logic [CNT_W-1:0] m_corr, m_unc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_syn(input logic [11:0] c);
    int s = 0;
    for (int pos = 1; pos <= 12; pos++) if (c[pos-1]) s = s ^ pos;
    return 4'(s);
  endfunction

  function automatic logic [3:0] m_crc(input logic [3:0] pay, input logic [7:0] poly);
    int t = int'(pay) * 16;
    int p = int'(poly[3:0]) * 16;
    for (int k = 7; k >= 4; k--) begin
      if (((t >> k) & 1) == 1) t = t ^ p;
      p = p / 2;
    end
    return 4'(t % 16);
  endfunction

  function automatic logic [15:0] m_encode(input logic [3:0] pay, input logic [7:0] poly);
    logic [7:0]  d;
    logic [11:0] c;
    logic [3:0]  s;
    d = {pay, m_crc(pay, poly)};
    c = '0;
    for (int i = 0; i < 8; i++) c[DPOS[i]-1] = d[i];
    s = m_syn(c);
    for (int j = 0; j < 4; j++) if (s[j]) c[(1 << j) - 1] = 1'b1;
    return {4'h0, c};
  endfunction

  function automatic logic [9:0] m_decode(input logic [15:0] code, input logic [7:0] poly);
    logic [11:0] c;
    logic [3:0]  s;
    logic [7:0]  d;
    logic        corr, unc;
    c = code[11:0];
    s = m_syn(c);
    corr = 1'b0;
    unc  = 1'b0;
    if (s >= 1 && s <= 12) begin
      c[s-1] = ~c[s-1];
      corr = 1'b1;
    end else if (s > 12) begin
      unc = 1'b1;
    end
    for (int i = 0; i < 8; i++) d[i] = c[DPOS[i]-1];
    if (m_crc(d[7:4], poly) != d[3:0]) unc = 1'b1;
    if (code[15:12] != 4'h0) unc = 1'b1;
    return {d[7:4], corr, unc, s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] code, input logic [7:0] poly, input logic [9:0] exp);
    int guard = 0;
    in_valid = 1'b1;
    in_code  = code;
    crc_poly = poly;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back(exp);
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [15:0] code, input logic [7:0] poly);
    send(code, poly, m_decode(code, poly));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  // out_ready generator, steered by bp_mode
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [9:0] e_mon;
  logic [9:0] hold_val;
  bit         hold_pend = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_corr    = '0;
      m_unc     = '0;
      hold_pend = 1'b0;
    end else begin
      check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
      check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_unc));
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_stable", 32'({out_data, out_corr, out_uncorr, out_syndrome}), 32'(hold_val));
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_data, out_corr, out_uncorr, out_syndrome};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e_mon = exp_q.pop_front();
          check("out_word", 32'({out_data, out_corr, out_uncorr, out_syndrome}), 32'(e_mon));
          if (!cnt_clr) begin
            if (e_mon[4]) begin
              if (m_unc != '1) m_unc = m_unc + 1'b1;
            end else if (e_mon[5]) begin
              if (m_corr != '1) m_corr = m_corr + 1'b1;
            end
          end
        end
      end
      if (cnt_clr) begin
        m_corr = '0;
        m_unc  = '0;
      end
    end
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0]  pay;
    logic [7:0]  poly;
    logic [15:0] code;
    int          acc0, b0, b1;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    crc_poly = 8'h07;
    cnt_clr  = 1'b0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_fields", 32'({out_data, out_corr, out_uncorr, out_syndrome}), 32'd0);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results
    send(16'h0A58, 8'h07, {4'hA, 1'b0, 1'b0, 4'h0});   // clean
    send(16'h0A78, 8'h07, {4'hA, 1'b1, 1'b0, 4'h6});   // bit 5 flipped
    send(16'h0A5B, 8'h07, {4'hA, 1'b1, 1'b1, 4'h3});   // bits 0,1: miscorrected, CRC fails
    send(16'h1A58, 8'h07, {4'hA, 1'b0, 1'b1, 4'h0});   // reserved nibble set
    send(16'h0259, 8'h07, {4'h2, 1'b0, 1'b1, 4'hD});   // syndrome 13, no flip
    drain();
    check("dir_corr_cnt", 32'(corr_cnt), 32'd1);
    check("dir_uncorr_cnt", 32'(uncorr_cnt), 32'd3);

    // Backpressure: consumer stalled, only two words fit
    bp_mode = 2;
    idle(2);
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(m_encode(4'(i + 3), 8'h07), 8'h07);
      end
    join_none
    repeat (5) @(negedge clk);
    check("bp_accepted", 32'(n_acc - acc0), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    bp_mode = 0;
    wait fork;
    drain();
    check("bp_all_accepted", 32'(n_acc - acc0), 32'd4);

    // Random traffic with random consumer backpressure and changing polynomials
    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      pay  = 4'($urandom_range(0, 15));
      poly = 8'($urandom);
      code = m_encode(pay, poly);
      case ($urandom_range(0, 4))
        0: ;
        1: code[$urandom_range(0, 11)] ^= 1'b1;
        2: begin
          b0 = $urandom_range(0, 11);
          b1 = (b0 + $urandom_range(1, 11)) % 12;
          code[b0] ^= 1'b1;
          code[b1] ^= 1'b1;
        end
        3: code[15:12] = 4'($urandom_range(1, 15));
        default: code = 16'($urandom);
      endcase
      send_m(code, poly);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
    bp_mode = 0;
    drain();

    // Saturation: 300 single-error words
    pulse_clr();
    for (int i = 0; i < 300; i++) begin
      pay  = 4'($urandom_range(0, 15));
      code = m_encode(pay, 8'h07);
      code[$urandom_range(0, 11)] ^= 1'b1;
      send_m(code, 8'h07);
    end
    drain();
    check("sat_corr_cnt", 32'(corr_cnt), 32'hFF);
    check("sat_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    // Reset with words in flight: they are discarded, counters cleared
    bp_mode = 2;
    idle(2);
    send_m(16'h0A58, 8'h07);
    send_m(16'h0A78, 8'h07);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("mid_rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bp_mode = 0;
    idle(2);
    send(16'h0A78, 8'h07, {4'hA, 1'b1, 1'b0, 4'h6});
    drain();
    check("post_rst_corr_cnt", 32'(corr_cnt), 32'd1);

    // Clear coincident with a stream of deliveries
    fork
      begin
        for (int i = 0; i < 20; i++) send_m(m_encode(4'(i), 8'h07) ^ 16'h0010, 8'h07);
      end
      begin
        idle(10);
        pulse_clr();
      end
    join
    drain();
    check("clr_corr_cnt", 32'(corr_cnt), 32'(m_corr));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
